// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the core (master) and
// dmem_responder (slave): valid/ready request channel and a one-cycle
// response pulse with no backpressure.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data-memory port.
// Owns a word-organised single-port RAM of MEMSIZE bytes. Full-word stores
// and loads take one access cycle; sub-word stores run a read-modify-write
// (RD -> MERGE). Out-of-range addresses (any bit set above the RAM size)
// are answered with rsp_err and never touch the RAM.
// Optional build macro DMEM_ALIGN_CHECK_EN: when defined, requests with
// req_addr[1:0] != 0 are also answered with rsp_err.
module dmem_responder #(
  parameter int unsigned MEMSIZE = 1024
) (
  input logic              clock,
  input logic              reset,   // asynchronous, active low
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW    = $clog2(MEMSIZE);
  localparam int unsigned WORDS = MEMSIZE / 4;
  localparam int unsigned IW    = AW - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MERGE,
    S_WR,
    S_ERR,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  // Latched request
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          wen_q, wen_d;

  // Response registers
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_load_q, rsp_load_d;
  logic rsp_err_q, rsp_err_d;

  // RAM and its read register
  logic [31:0] mem [WORDS];
  logic [31:0] rd_q;
  logic        rd_en;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] merged;

  logic accept;
  logic range_err;
  logic align_err;
  logic req_err;
  logic full_or_empty_store;

  assign accept    = bus.req_valid && (state_q == S_IDLE);
  assign range_err = (bus.req_addr >> AW) != 32'd0;

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = (bus.req_addr[1:0] != 2'b00);
`else
  assign align_err = 1'b0;
`endif

  assign req_err             = range_err || align_err;
  assign full_or_empty_store = bus.req_wen &&
                               ((bus.req_be == 4'hF) || (bus.req_be == 4'h0));

  // Byte-lane merge of the old word with the enabled store lanes
  always_comb begin
    merged = rd_q;
    for (int unsigned k = 0; k < 4; k++) begin
      if (be_q[k]) merged[8*k +: 8] = wdata_q[8*k +: 8];
    end
  end

  // Next-state, RAM control and response next-values
  always_comb begin
    state_d     = state_q;
    rd_en       = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = wdata_q;
    rsp_load_d  = 1'b0;
    rsp_err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                  state_d = S_ERR;
          else if (full_or_empty_store) state_d = S_WR;
          else                          state_d = S_RD;
        end
      end
      S_RD: begin
        rd_en = 1'b1;
        if (wen_q) begin
          state_d = S_MERGE;
        end else begin
          state_d    = S_RESP;
          rsp_load_d = 1'b1;
        end
      end
      S_MERGE: begin
        mem_we    = 1'b1;
        mem_wdata = merged;
        state_d   = S_RESP;
      end
      S_WR: begin
        // be==0 is acknowledged without touching the RAM
        mem_we  = (be_q == 4'hF);
        state_d = S_RESP;
      end
      S_ERR: begin
        rsp_err_d = 1'b1;
        state_d   = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    rsp_valid_d = (state_d == S_RESP);
  end

  // Request latch next-values: capture only on the accept edge
  always_comb begin
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wen_d   = wen_q;
    if (accept) begin
      idx_d   = bus.req_addr[AW-1:2];
      wdata_d = bus.req_wdata;
      be_d    = bus.req_be;
      wen_d   = bus.req_wen;
    end
  end

  // Control and request registers; reset aborts any request in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      wen_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_load_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      wen_q       <= wen_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_load_q  <= rsp_load_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Single-port RAM: contents survive reset. Writes only happen from
  // MERGE/WR, which reset forces out of asynchronously, so an aborted
  // store never reaches the array.
  always_ff @(posedge clock) begin
    if (mem_we) mem[idx_q] <= mem_wdata;
    if (rd_en)  rd_q       <= mem[idx_q];
  end

  // rd_q is only loaded in RD, which for loads is followed directly by
  // RESP, so gating it with the registered load flag yields the load word
  // during RESP and zero everywhere else.
  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_load_q ? rd_q : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed steps plus randomized
// traffic, checked against a byte-level reference memory model.
module tb_dmem_responder;

  localparam int unsigned MEMSIZE = 1024;
  localparam int unsigned WORDS   = MEMSIZE / 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.MEMSIZE(MEMSIZE)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  logic [31:0] model [WORDS];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request at the next falling edge and check the response.
  // req_valid is left high afterwards; the next call replaces the request
  // during the following IDLE cycle.
  task automatic req(input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input string tag);
    logic        err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          lat;
    bit          seen;
    int unsigned idx;

    idx       = (addr >> 2) % WORDS;
    err       = (addr >= MEMSIZE);
`ifdef DMEM_ALIGN_CHECK_EN
    if (addr[1:0] != 2'b00) err = 1'b1;
`endif
    exp_rdata = '0;
    exp_lat   = 2;
    if (!err) begin
      if (!wen) begin
        exp_rdata = model[idx];
      end else begin
        for (int k = 0; k < 4; k++)
          if (be[k]) model[idx][8*k +: 8] = wdata[8*k +: 8];
        if (be != 4'hF && be != 4'h0) exp_lat = 3;
      end
    end

    @(negedge clk);
    chk({tag, ".ready_idle"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_wen   = wen;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;

    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      lat = c;
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
      else chk({tag, ".ready_busy"}, {31'd0, bus.req_ready}, 32'd0);
    end
    if (!seen) lat = 99;
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".err"}, {31'd0, bus.rsp_err}, {31'd0, err});
    chk({tag, ".rdata"}, bus.rsp_rdata, exp_rdata);
    chk({tag, ".ready_rsp"}, {31'd0, bus.req_ready}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int unsigned r;

    bus.req_valid = 1'b0;
    bus.req_wen   = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;

    // Reset state
    #2 rst_n = 1'b0;
    #10;
    chk("reset.ready", {31'd0, bus.req_ready}, 32'd1);
    chk("reset.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset.rdata", bus.rsp_rdata, 32'd0);
    chk("reset.err", {31'd0, bus.rsp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill the whole RAM so the model is fully known
    for (int i = 0; i < WORDS; i++) req(1'b1, i * 4, $urandom, 4'hF, "fill");

    // Full store then load
    req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "full_st");
    req(1'b0, 32'h10, 32'h0, 4'h0, "full_ld");

    // Partial store via read-modify-write
    req(1'b1, 32'h20, 32'h11223344, 4'hF, "pre20");
    req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "part_st");
    req(1'b0, 32'h20, 32'h0, 4'h0, "part_ld");

    // Empty-mask store is a no-op
    req(1'b1, 32'h24, 32'hCAFEF00D, 4'h0, "be0_st");
    req(1'b0, 32'h24, 32'h0, 4'hF, "be0_ld");

    // Out of range, including wrap-like addresses
    req(1'b0, 32'h400, 32'h0, 4'h0, "oor_ld400");
    req(1'b1, 32'hFFFF_FFFC, 32'h12345678, 4'hF, "oor_stFFFC");
    req(1'b1, 32'h404, 32'h12345678, 4'b0011, "oor_part");
    req(1'b0, 32'h8000_0000, 32'h0, 4'h0, "oor_msb");

    // Misaligned load of word 0x10
    req(1'b0, 32'h13, 32'h0, 4'h0, "align_ld13");
    req(1'b1, 32'h11, 32'h01020304, 4'b0010, "align_st11");
    req(1'b0, 32'h10, 32'h0, 4'h0, "align_chk10");

    // Randomized traffic, back to back with req_valid held high
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 7);
      if (r == 0) a = $urandom | 32'h0000_0400;
      else a = $urandom_range(0, MEMSIZE - 1);
      if (r > 2) a[1:0] = 2'b00;
      req($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)), "rand");
    end

    // Reset while in MERGE of a partial store: no write, no response
    req(1'b1, 32'h30, 32'h55667788, 4'hF, "pre30");
    bus.req_valid = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b1;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'h000000AA;
    bus.req_be    = 4'b0001;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst_rmw.in_rd_ready", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    chk("rst_rmw.in_merge_valid", {31'd0, bus.rsp_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_rmw.ready_async", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rmw.valid_async", {31'd0, bus.rsp_valid}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_rmw.valid_held", {31'd0, bus.rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_rmw.valid_after", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_rmw.ready_after", {31'd0, bus.req_ready}, 32'd1);
    end
    req(1'b0, 32'h30, 32'h0, 4'h0, "rst_rmw.ld30");

    // Every word must match the model (nothing corrupted by errors)
    for (int i = 0; i < WORDS; i++) req(1'b0, i * 4, 32'h0, 4'h0, "sweep");

    // No spurious acceptance or response once req_valid drops
    bus.req_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("idle.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("idle.ready", {31'd0, bus.req_ready}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port: accepts load/store requests over a valid/ready handshake and returns a single-cycle response pulse.
- Owns a word-organised single-port RAM. Sub-word stores are executed as an internal read-modify-write (RMW) sequence.
- Replaces the direct rwmemory hookup in top once the core drives byte enables and honours req_ready.

Parameters:
- MEMSIZE, 1024, RAM size in bytes; power of two, multiple of 4; word count is MEMSIZE/4.
- AW, $clog2(MEMSIZE), derived byte-address width used for range checking; not overridable.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_wen  in  1  1=store, 0=load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, lane-aligned (byte k on bits 8k+7:8k).
- req_be  in  4  store byte enables; ignored for loads.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load data, full word; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid; request was rejected.

Behaviour:
- Reset (asynchronous, reset low): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. Latched request registers are cleared. RAM contents are not altered.
- Reset mid-operation aborts the request. A partial store still in RD or MERGE performs no RAM write; a full store in WR performs no write unless reset was released before that edge. No response is produced.
- Accept rule: the request is taken on the edge where req_valid && req_ready. At that edge addr, wdata, be and wen are latched. Request inputs are don't-care in all other cycles.
- States and transitions:
  - IDLE: on accept, go to ERR if req_addr[31:AW] != 0; else WR if req_wen && req_be==4'hF; else WR if req_wen && req_be==4'h0; else RD.
  - RD: synchronous RAM read of word addr[AW-1:2], captured at the next edge. Go to MERGE if wen, else to RESP with rsp_rdata = read word.
  - MERGE: per lane k, merged byte = be[k] ? wdata byte k : old byte k. Merged word written at this edge; go to RESP.
  - WR: if be==4'hF, write wdata at this edge. If be==0, no write (store is acknowledged as a no-op). Go to RESP.
  - ERR: no RAM access; go to RESP with rsp_err=1.
  - RESP: rsp_valid=1 for exactly this cycle; go to IDLE.
- rsp_valid, rsp_rdata and rsp_err are registered and driven only in RESP. Outside RESP they are 0.
- Latency, counted from acceptance edge N:
  - Loads, full stores and errors: rsp_valid is high during the cycle after edge N+1.
  - Partial stores: rsp_valid is high during the cycle after edge N+2.
- Back-to-back throughput: one load every 3 cycles; one partial store every 4 cycles.
- The initiator must always accept rsp_valid; there is no response backpressure.
- Without DMEM_ALIGN_CHECK_EN, addr[1:0] is ignored: the word is selected by addr[AW-1:2].
- Address check uses the full 32 bits: any set bit in [31:AW] is an error, including wrap-like addresses such as MEMSIZE or 0xFFFF_FFFC.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- When defined: in IDLE, a request with req_addr[1:0] != 0 goes to ERR (rsp_err=1, no RAM write, rsp_rdata=0). The address range check still applies.
- When undefined: addr[1:0] is ignored as stated in Behaviour; no alignment errors are ever raised.

Test Plan:
- Full store then load: store addr 0x10, data 0xDEADBEEF, be=F -> rsp_valid 2 cycles after accept, err=0; load 0x10 -> rdata 0xDEADBEEF.
- Partial store: preload 0x20 with 0x11223344; store be=4'b0101, wdata 0xAABBCCDD -> rsp 3 cycles after accept; load 0x20 -> 0x11BB33DD.
- Out of range: load 0x400 and store 0xFFFF_FFFC with MEMSIZE=1024 -> rsp_err=1, rdata 0; every word unchanged.
- Handshake: hold req_valid high continuously -> req_ready low in all non-IDLE states; exactly one response per acceptance; no acceptance while rsp_valid=1.
- Reset mid-RMW: assert reset while in MERGE for store be=4'b0001 to 0x30 (old 0x55667788) -> rsp_valid stays 0; after release, load 0x30 returns 0x55667788.
- Alignment: load 0x13 -> with DMEM_ALIGN_CHECK_EN, rsp_err=1; without it, data of word 0x10 with err=0.
